// File: rtl/rs_forney_seq_if.sv
// Job / result streams of the Forney error-magnitude evaluator.
interface rs_forney_seq_if #(
    parameter int SYMB_WIDTH = 8,
    parameter int T_LEN      = 8,
    parameter int ROOTS_NUM  = 2 * T_LEN
);
    logic                                  s_vld;
    logic                                  s_rdy;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0]      s_err_pos;
    logic [T_LEN-1:0]                      s_err_vld;
    logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  s_synd;
    logic                                  m_vld;
    logic                                  m_rdy;
    logic [SYMB_WIDTH-1:0]                 m_pos;
    logic [SYMB_WIDTH-1:0]                 m_mag;
    logic                                  m_last;
    logic                                  m_fail;

    // Environment side: issues jobs, consumes result beats.
    modport master (
        output s_vld, s_err_pos, s_err_vld, s_synd, m_rdy,
        input  s_rdy, m_vld, m_pos, m_mag, m_last, m_fail
    );

    // Evaluator side.
    modport slave (
        input  s_vld, s_err_pos, s_err_vld, s_synd, m_rdy,
        output s_rdy, m_vld, m_pos, m_mag, m_last, m_fail
    );
endinterface

// File: rtl/rs_forney_seq.sv
// GF(2^w) arithmetic helpers plus the sequential Forney evaluator.
package gf_pkg;
    localparam int unsigned GF_MAXW = 16;
    typedef logic [GF_MAXW-1:0] gf_t;

    function automatic logic [GF_MAXW:0] prim_poly(input int unsigned w);
        case (w)
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            16:      return 17'h1100B;
            default: return 17'h0011D;
        endcase
    endfunction

    function automatic gf_t gf_mult(input gf_t a, input gf_t b, input int unsigned w);
        logic [GF_MAXW:0] sh;
        logic [GF_MAXW:0] poly;
        logic [GF_MAXW:0] top;
        gf_t              res;
        sh   = {1'b0, a};
        poly = prim_poly(w);
        top  = 17'd1 << w;
        res  = '0;
        for (int unsigned i = 0; i < GF_MAXW; i++) begin
            if (i < w) begin
                if (b[i]) res ^= sh[GF_MAXW-1:0];
                sh = sh << 1;
                if ((sh & top) != '0) sh ^= poly;
            end
        end
        return res;
    endfunction

    // a^(2^w - 2) = product of a^(2^i), i = 1..w-1; maps 0 to 0
    function automatic gf_t gf_inv(input gf_t a, input int unsigned w);
        gf_t r;
        gf_t s;
        r = gf_t'(1);
        s = a;
        for (int unsigned i = 1; i < GF_MAXW; i++) begin
            if (i < w) begin
                s = gf_mult(s, s, w);
                r = gf_mult(r, s, w);
            end
        end
        return r;
    endfunction

    function automatic gf_t gf_pow(input gf_t base, input gf_t e, input int unsigned w);
        gf_t r;
        gf_t s;
        r = gf_t'(1);
        s = base;
        for (int unsigned i = 0; i < GF_MAXW; i++) begin
            if (i < w) begin
                if (e[i]) r = gf_mult(r, s, w);
                s = gf_mult(s, s, w);
            end
        end
        return r;
    endfunction

    function automatic gf_t pow_first_root(input gf_t e, input int unsigned w);
        return gf_pow(gf_t'(2), e, w);
    endfunction
endpackage

module rs_forney_seq #(
    parameter int SYMB_WIDTH = 8,
    parameter int T_LEN      = 8,
    parameter int ROOTS_NUM  = 2 * T_LEN,
    parameter int N_LEN      = 255,
    parameter int FCR        = 0
) (
    input  logic               aclk,
    input  logic               areset,
    rs_forney_seq_if.slave     bus
);
    import gf_pkg::*;

    localparam int NQ  = (1 << SYMB_WIDTH) - 1;
    localparam int K1I = (((1 - FCR) % NQ) + NQ) % NQ;
    localparam int EW  = $clog2(T_LEN + 1);
    localparam int IW  = (T_LEN > 1) ? $clog2(T_LEN) : 1;
    localparam int KW  = (ROOTS_NUM > 1) ? $clog2(ROOTS_NUM) : 1;

    typedef logic [SYMB_WIDTH-1:0] sym_t;
    localparam sym_t K1 = sym_t'(K1I);

    function automatic sym_t mul(input sym_t a, input sym_t b);
        return sym_t'(gf_mult(gf_t'(a), gf_t'(b), SYMB_WIDTH));
    endfunction
    function automatic sym_t inv(input sym_t a);
        return sym_t'(gf_inv(gf_t'(a), SYMB_WIDTH));
    endfunction
    function automatic sym_t xpow(input sym_t a, input sym_t e);
        return sym_t'(gf_pow(gf_t'(a), gf_t'(e), SYMB_WIDTH));
    endfunction
    function automatic sym_t alpha_pow(input sym_t e);
        return sym_t'(pow_first_root(gf_t'(e), SYMB_WIDTH));
    endfunction

    typedef enum logic [2:0] {IDLE, LOC, OMEGA, EVAL, DIV, OUT} state_t;
    state_t state, state_nxt;

    sym_t          pos_r  [T_LEN];
    sym_t          synd_r [ROOTS_NUM];
    sym_t          lam    [T_LEN+1];
    sym_t          omg    [ROOTS_NUM];
    logic [EW-1:0] e_cnt, e_in;
    logic [IW-1:0] j;
    logic [KW-1:0] k;
    sym_t          acc_o, acc_l;
    sym_t          out_pos, out_mag;
    logic          out_last, out_fail;

    logic          run;
    logic          j_last;
    logic          div_fail;
    sym_t          cur_pos, cur_x, xi, omega_k, d_k, div_mag;

    // Error count: leading run of ones in the position-valid mask.
    always_comb begin
        e_in = '0;
        run  = 1'b1;
        for (int unsigned i = 0; i < T_LEN; i++) begin
            if (run && bus.s_err_vld[i]) e_in = e_in + EW'(1);
            else                         run  = 1'b0;
        end
    end

    // Per-cycle field terms: locator root, Omega coefficient, derivative tap, quotient.
    always_comb begin
        cur_pos = pos_r[j];
        cur_x   = alpha_pow(sym_t'(N_LEN - 1) - cur_pos);
        xi      = inv(cur_x);
        j_last  = (EW'(j) + EW'(1)) == e_cnt;
        omega_k = '0;
        for (int unsigned i = 0; i <= T_LEN; i++) begin
            if (i <= 32'(k)) omega_k ^= mul(lam[i], synd_r[k - KW'(i)]);
        end
        d_k = '0;
        for (int unsigned i = 0; i < T_LEN; i++) begin
            if ((i % 2 == 0) && (i < ROOTS_NUM) && (KW'(i) == k)) d_k = lam[i+1];
        end
        div_fail = (acc_l == '0);
        div_mag  = div_fail ? '0 : mul(mul(xpow(cur_x, K1), acc_o), inv(acc_l));
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.s_vld && (e_in != '0)) state_nxt = LOC;
            LOC:     if (j_last) state_nxt = OMEGA;
            OMEGA:   if (k == KW'(ROOTS_NUM - 1)) state_nxt = EVAL;
            EVAL:    if (k == '0) state_nxt = DIV;
            DIV:     state_nxt = OUT;
            OUT:     if (bus.m_rdy) state_nxt = j_last ? IDLE : EVAL;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and result outputs, forced to zero while in reset.
    always_comb begin
        bus.s_rdy  = !areset && (state == IDLE);
        bus.m_vld  = !areset && (state == OUT);
        bus.m_pos  = areset ? '0 : out_pos;
        bus.m_mag  = areset ? '0 : out_mag;
        bus.m_last = !areset && out_last;
        bus.m_fail = !areset && out_fail;
    end

    // Datapath: capture, locator product, Omega, Horner evaluation, division.
    always_ff @(posedge aclk) begin
        if (areset) begin
            e_cnt    <= '0;
            j        <= '0;
            k        <= '0;
            acc_o    <= '0;
            acc_l    <= '0;
            out_pos  <= '0;
            out_mag  <= '0;
            out_last <= 1'b0;
            out_fail <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.s_vld) begin
                    for (int unsigned i = 0; i < T_LEN; i++) pos_r[i] <= bus.s_err_pos[i];
                    for (int unsigned i = 0; i < ROOTS_NUM; i++) synd_r[i] <= bus.s_synd[i];
                    for (int unsigned i = 1; i <= T_LEN; i++) lam[i] <= '0;
                    lam[0] <= sym_t'(1);
                    e_cnt  <= e_in;
                    j      <= '0;
                    k      <= '0;
                end
                LOC: begin
                    for (int unsigned i = 1; i <= T_LEN; i++) lam[i] <= lam[i] ^ mul(cur_x, lam[i-1]);
                    if (j_last) j <= '0;
                    else        j <= j + IW'(1);
                    k <= '0;
                end
                OMEGA: begin
                    omg[k] <= omega_k;
                    // k parks at ROOTS_NUM-1, which is where the Horner loop starts
                    if (k == KW'(ROOTS_NUM - 1)) begin
                        acc_o <= '0;
                        acc_l <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                EVAL: begin
                    acc_o <= mul(acc_o, xi) ^ omg[k];
                    acc_l <= mul(acc_l, xi) ^ d_k;
                    if (k != '0) k <= k - KW'(1);
                end
                DIV: begin
                    out_pos  <= cur_pos;
                    out_mag  <= div_mag;
                    out_fail <= div_fail;
                    out_last <= j_last;
                end
                OUT: if (bus.m_rdy && !j_last) begin
                    j     <= j + IW'(1);
                    k     <= KW'(ROOTS_NUM - 1);
                    acc_o <= '0;
                    acc_l <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
